// File: rtl/issue_ctrl_if.sv
// Decode-to-execute handshake bundle for issue_ctrl.
// The slave side is the issue stage; the master side drives decode/execute.
interface issue_ctrl_if #(
  parameter int AWIDTH = 32
);
  logic              dec_valid_i;
  logic [AWIDTH-1:0] pc_i;
  logic [6:0]        opcode_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic              ex_ready_i;
  logic              dec_ready_o;
  logic              issue_valid_o;
  logic [AWIDTH-1:0] pc_o;

  modport slave (
    input  dec_valid_i, pc_i, opcode_i,
    input  rd_i, rs1_i, rs2_i, ex_ready_i,
    output dec_ready_o, issue_valid_o, pc_o
  );

  modport master (
    output dec_valid_i, pc_i, opcode_i,
    output rd_i, rs1_i, rs2_i, ex_ready_i,
    input  dec_ready_o, issue_valid_o, pc_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue control: register scoreboard, RAW/WAW hazard stall,
// flush handling and a saturating stall-cycle counter.
module issue_ctrl #(
  parameter int AWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  issue_ctrl_if.slave     dec,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            flush_i,
  output logic [31:0]     busy_o,
  output logic [1:0]      state_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       busy_q, busy_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [31:0]       wb_mask, eff_busy;
  logic              use_rs1, use_rs2, use_rd;
  logic              haz, fire, stall_req;
  logic [AWIDTH-1:0] pc_w;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (dec.opcode_i)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        use_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  // A retiring write is bypassed in the same cycle it clears the bit.
  assign wb_mask  = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
  assign eff_busy = busy_q & ~wb_mask;

  assign haz = (use_rs1 && dec.rs1_i != 5'd0 && eff_busy[dec.rs1_i])
            || (use_rs2 && dec.rs2_i != 5'd0 && eff_busy[dec.rs2_i])
            || (use_rd  && dec.rd_i  != 5'd0 && eff_busy[dec.rd_i]);

  assign dec.issue_valid_o = dec.dec_valid_i & ~haz & ~flush_i
                           & (state_q != FLUSH);
  assign fire              = dec.issue_valid_o & dec.ex_ready_i;
  assign dec.dec_ready_o   = fire | (flush_i & dec.dec_valid_i);
  assign pc_w              = dec.pc_i;
  assign dec.pc_o          = pc_w;
  assign stall_req         = dec.dec_valid_i & haz;

  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (fire && use_rd && dec.rd_i != 5'd0)
      busy_d[dec.rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN:     if (stall_req) state_d = STALL;
        STALL:   if (!stall_req) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == STALL && cnt_q != {CNTW{1'b1}})
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      busy_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign state_o     = state_q;
  assign stall_cnt_o = cnt_q;

endmodule
